// File: rtl/add_share_arb.sv
// Round-robin sequencer sharing one 16-bit carry-look-ahead adder among three requesters.
// Build option: define ADD_SHARE_ARB_SAT_EN to saturate rsum on signed overflow.
module add_share_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] a0,
  input  logic [15:0] b0,
  input  logic [15:0] a1,
  input  logic [15:0] b1,
  input  logic [15:0] a2,
  input  logic [15:0] b2,
  input  logic [2:0]  sub,
  output logic [2:0]  gnt,
  output logic        rvalid,
  output logic [15:0] rsum,
  output logic        rovfl,
  output logic [1:0]  rid,
  input  logic        rack
);

  typedef enum logic [1:0] {IDLE, ADD, RESP} state_t;

  state_t             state_q;
  logic [1:0]         ptr_q;
  logic [1:0]         id_q;
  logic signed [15:0] opa_q;
  logic signed [15:0] opb_q;
  logic               cin_q;

  logic [1:0]         win_d;
  logic               win_vld_d;
  logic [15:0]        a_w_d;
  logic [15:0]        b_w_d;
  logic               s_w_d;
  logic signed [15:0] sum_d;
  logic               ovf_d;
  logic signed [15:0] res_d;

  function automatic logic [1:0] rr_idx(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  // Two-level adder: 4-bit groups ripple internally, group carries come from lookahead terms.
  function automatic logic [15:0] cla16(input logic [15:0] a, input logic [15:0] b,
                                        input logic cin);
    logic [15:0] g;
    logic [15:0] p;
    logic [15:0] c;
    logic [2:0]  gg;
    logic [2:0]  gp;
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++)
        c[4*k+j+1] = g[4*k+j] | (p[4*k+j] & c[4*k+j]);
      if (k < 3) begin
        gg[k] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1]) |
                (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        gp[k] = &p[4*k +: 4];
        c[4*k+4] = gg[k] | (gp[k] & c[4*k]);
      end
    end
    return p ^ c;
  endfunction

`ifdef ADD_SHARE_ARB_SAT_EN
  function automatic logic signed [15:0] sat16(input logic signed [15:0] s, input logic ovf,
                                               input logic a_msb);
    if (ovf) return a_msb ? 16'sh8000 : 16'sh7FFF;
    return s;
  endfunction
`endif

  // Winner: first set request scanning ptr, ptr+1, ptr+2 (mod 3).
  always_comb begin
    win_d     = ptr_q;
    win_vld_d = 1'b0;
    if (req[ptr_q]) begin
      win_d = ptr_q; win_vld_d = 1'b1;
    end else if (req[rr_idx(ptr_q, 2'd1)]) begin
      win_d = rr_idx(ptr_q, 2'd1); win_vld_d = 1'b1;
    end else if (req[rr_idx(ptr_q, 2'd2)]) begin
      win_d = rr_idx(ptr_q, 2'd2); win_vld_d = 1'b1;
    end
  end

  always_comb begin
    a_w_d = a2;
    b_w_d = b2;
    s_w_d = sub[2];
    case (win_d)
      2'd0: begin a_w_d = a0; b_w_d = b0; s_w_d = sub[0]; end
      2'd1: begin a_w_d = a1; b_w_d = b1; s_w_d = sub[1]; end
      default: ;
    endcase
  end

  // Overflow comes from operand/sum signs; opB is already inverted for subtraction.
  assign sum_d = cla16(opa_q, opb_q, cin_q);
  assign ovf_d = (opa_q[15] == opb_q[15]) && (sum_d[15] != opa_q[15]);
`ifdef ADD_SHARE_ARB_SAT_EN
  assign res_d = sat16(sum_d, ovf_d, opa_q[15]);
`else
  assign res_d = sum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      id_q    <= 2'd0;
      opa_q   <= '0;
      opb_q   <= '0;
      cin_q   <= 1'b0;
      gnt     <= 3'b000;
      rvalid  <= 1'b0;
      rsum    <= 16'h0000;
      rovfl   <= 1'b0;
      rid     <= 2'd0;
    end else begin
      case (state_q)
        IDLE: if (win_vld_d) begin
          opa_q   <= a_w_d;
          opb_q   <= s_w_d ? ~b_w_d : b_w_d;
          cin_q   <= s_w_d;
          id_q    <= win_d;
          gnt     <= 3'b001 << win_d;
          ptr_q   <= rr_idx(win_d, 2'd1);
          state_q <= ADD;
        end
        ADD: begin
          gnt     <= 3'b000;
          rsum    <= res_d;
          rovfl   <= ovf_d;
          rid     <= id_q;
          rvalid  <= 1'b1;
          state_q <= RESP;
        end
        RESP: if (rack) begin
          rvalid  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_share_arb.sv
// Scoreboard bench for add_share_arb: driver queues expected grants/results, monitors pop and compare.
module tb_add_share_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  sub = 3'b000;
  logic [15:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0, a2 = '0, b2 = '0;
  logic        rack = 1'b1;
  logic [2:0]  gnt;
  logic        rvalid;
  logic [15:0] rsum;
  logic        rovfl;
  logic [1:0]  rid;

  add_share_arb dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1), .a2(a2), .b2(b2),
    .sub(sub), .gnt(gnt), .rvalid(rvalid), .rsum(rsum), .rovfl(rovfl), .rid(rid),
    .rack(rack)
  );

  always #5 clk = ~clk;

`ifdef ADD_SHARE_ARB_SAT_EN
  localparam logic [15:0] E_POS_OVF = 16'h7FFF;
  localparam logic [15:0] E_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] E_POS_OVF = 16'h8000;
  localparam logic [15:0] E_NEG_OVF = 16'h7FFF;
`endif

  int total  = 0;
  int passed = 0;
  logic [18:0] rq[$];   // {rid, rovfl, rsum}
  logic [1:0]  gq[$];

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Result monitor: compare on rvalid rise, then require stability while held.
  logic        prev_v = 1'b0;
  logic [18:0] hold_exp = '0;
  always @(negedge clk) begin
    if (rvalid === 1'b1 && !prev_v) begin
      if (rq.size() == 0) begin
        total++;
        $display("FAIL unexpected_rvalid: got rid=%0d rsum=0x%h, none expected", rid, rsum);
      end else begin
        hold_exp = rq.pop_front();
        check("result", {rid, rovfl, rsum}, hold_exp);
      end
    end else if (rvalid === 1'b1 && prev_v) begin
      check("result_hold", {rid, rovfl, rsum}, hold_exp);
    end
    prev_v = (rvalid === 1'b1);
  end

  // Grant monitor.
  logic [1:0] gid;
  always @(negedge clk) begin
    if (gnt !== 3'b000 && !$isunknown(gnt)) begin
      if (gq.size() == 0) begin
        total++;
        $display("FAIL unexpected_gnt: got %b, none expected", gnt);
      end else begin
        gid = gq.pop_front();
        check("gnt", 19'(gnt), 19'(3'b001 << gid));
      end
    end
  end

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (gnt === 3'b000 && n < 30);
    if (gnt === 3'b000) begin
      total++;
      $display("FAIL gnt_timeout: got no gnt after %0d cycles, required one", n);
    end
  endtask

  task automatic issue(input logic [1:0] id, input logic [15:0] a, input logic [15:0] b,
                       input logic s, input logic push_res, input logic [18:0] exp,
                       output int n);
    case (id)
      2'd0: begin a0 = a; b0 = b; end
      2'd1: begin a1 = a; b1 = b; end
      default: begin a2 = a; b2 = b; end
    endcase
    sub[id] = s;
    req[id] = 1'b1;
    gq.push_back(id);
    if (push_res) rq.push_back(exp);
    wait_gnt(n);
    req[id] = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while ((rq.size() != 0 || gq.size() != 0) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (rq.size() != 0 || gq.size() != 0) begin
      total++;
      $display("FAIL drain: got %0d results and %0d grants outstanding, required 0",
               rq.size(), gq.size());
      rq.delete();
      gq.delete();
    end
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 19'(gnt), 19'd0);
    check("rst_rvalid", 19'(rvalid), 19'd0);
    check("rst_rsum", 19'(rsum), 19'd0);
    check("rst_rovfl", 19'(rovfl), 19'd0);
    check("rst_rid", 19'(rid), 19'd0);
    rst = 1'b0;

    // Basic add, latency to gnt and rvalid.
    issue(2'd0, 16'h1234, 16'h0001, 1'b0, 1'b1, {2'd0, 1'b0, 16'h1235}, n);
    check("gnt_latency", 19'(n), 19'd1);
    @(posedge clk); #1;
    check("rvalid_latency", 19'(rvalid), 19'd1);
    issue(2'd2, 16'h0005, 16'h0007, 1'b1, 1'b1, {2'd2, 1'b0, 16'hFFFE}, n);
    issue(2'd1, 16'h7FFF, 16'h0001, 1'b0, 1'b1, {2'd1, 1'b1, E_POS_OVF}, n);
    issue(2'd1, 16'h8000, 16'h0001, 1'b1, 1'b1, {2'd1, 1'b1, E_NEG_OVF}, n);
    drain();

    // Round robin from ptr=0 with all requests held.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    a0 = 16'h0010; b0 = 16'h0001;
    a1 = 16'h0100; b1 = 16'h0002;
    a2 = 16'h7000; b2 = 16'h1000;
    sub = 3'b010;
    gq.push_back(2'd0); gq.push_back(2'd1); gq.push_back(2'd2);
    gq.push_back(2'd0); gq.push_back(2'd1);
    rq.push_back({2'd0, 1'b0, 16'h0011});
    rq.push_back({2'd1, 1'b0, 16'h00FE});
    rq.push_back({2'd2, 1'b1, E_POS_OVF});
    rq.push_back({2'd0, 1'b0, 16'h0011});
    rq.push_back({2'd1, 1'b0, 16'h00FE});
    req = 3'b111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(n);
      if (i > 0) check("rr_interval", 19'(n), 19'd3);
    end
    req = 3'b000;
    sub = 3'b000;
    drain();

    // Back-pressure: result held while rack is low, pending request waits.
    rack = 1'b0;
    issue(2'd1, 16'h0003, 16'h0004, 1'b0, 1'b1, {2'd1, 1'b0, 16'h0007}, n);
    @(posedge clk); #1;
    a1 = 16'h0020; b1 = 16'h0008; sub[1] = 1'b1;
    req = 3'b010;
    gq.push_back(2'd1);
    rq.push_back({2'd1, 1'b0, 16'h0018});
    repeat (5) begin
      @(posedge clk); #1;
      check("hold_no_gnt", 19'(gnt), 19'd0);
      check("hold_rvalid", 19'(rvalid), 19'd1);
    end
    rack = 1'b1;
    wait_gnt(n);
    check("rack_to_gnt", 19'(n), 19'd2);
    req = 3'b000;
    sub = 3'b000;
    drain();

    // Reset during ADD abandons the operation and restores ptr=0.
    issue(2'd1, 16'h0001, 16'h0002, 1'b0, 1'b0, '0, n);
    rst = 1'b1;
    @(posedge clk); #1;
    check("addrst_gnt", 19'(gnt), 19'd0);
    check("addrst_rvalid", 19'(rvalid), 19'd0);
    check("addrst_rsum", 19'(rsum), 19'd0);
    check("addrst_rovfl", 19'(rovfl), 19'd0);
    check("addrst_rid", 19'(rid), 19'd0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    a0 = 16'h0001; b0 = 16'h0001;
    a2 = 16'h8000; b2 = 16'hFFFF;
    sub = 3'b001;
    gq.push_back(2'd0); gq.push_back(2'd2);
    rq.push_back({2'd0, 1'b0, 16'h0000});
    rq.push_back({2'd2, 1'b1, E_NEG_OVF});
    req = 3'b101;
    wait_gnt(n);
    check("rst_ptr_first", 19'(gnt), 19'b001);
    req[0] = 1'b0;
    wait_gnt(n);
    req = 3'b000;
    drain();

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
